set_assoc_cache: RTL

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_way.sv | 63 ++++++
 rtl/set_assoc_cache.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared defaults, FSM state encoding and address split helpers for set_assoc_cache
package cache_pkg;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INDEX_W = 10;
  localparam int DEF_WAYS    = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE        = 3'd0;
  localparam state_t S_LOOKUP      = 3'd1;
  localparam state_t S_WRITEBACK   = 3'd2;
  localparam state_t S_REFILL_REQ  = 3'd3;
  localparam state_t S_REFILL_WAIT = 3'd4;
  localparam state_t S_RESPOND     = 3'd5;

  // Callers zero-extend the address to 32 bits and cast the result back to tag/index width.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
    return addr >> index_w;
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one cache way: tag/data arrays plus valid/dirty bits per set, with tag compare
module cache_way #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   cmp_tag,
  output logic               hit,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_dirty
);

  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      dirty_d[wr_index] = wr_dirty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];
  assign hit      = rd_valid && (rd_tag == cmp_tag);

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-back, write-allocate set-associative cache, one word per line
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int WAYS    = DEF_WAYS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [WAY_W-1:0]  rr_q [SETS];
  logic [WAY_W-1:0]  rr_cur, rr_d;
  logic              rr_we;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [WAYS-1:0]    way_hit, way_valid, way_dirty, way_wr_en;
  logic [TAG_W-1:0]   way_tag  [WAYS];
  logic [DATA_W-1:0]  way_data [WAYS];
  logic [DATA_W-1:0]  wr_data;
  logic               wr_dirty;
  logic               any_hit, any_invalid;
  logic [WAY_W-1:0]   hit_way, victim_sel;

  assign req_tag   = TAG_W'(addr_tag(32'(req_addr_q), INDEX_W));
  assign req_index = INDEX_W'(addr_index(32'(req_addr_q), INDEX_W));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (req_index),
      .cmp_tag  (req_tag),
      .hit      (way_hit[w]),
      .rd_valid (way_valid[w]),
      .rd_dirty (way_dirty[w]),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w]),
      .wr_en    (way_wr_en[w]),
      .wr_index (req_index),
      .wr_tag   (req_tag),
      .wr_data  (wr_data),
      .wr_dirty (wr_dirty)
    );
  end

  assign rr_cur = rr_q[req_index];
  assign rr_d   = (rr_cur == WAY_W'(WAYS - 1)) ? '0 : rr_cur + WAY_W'(1);

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    any_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    victim_sel  = rr_cur;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        any_invalid = 1'b1;
        victim_sel  = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    req_we_d        = req_we_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    victim_d        = victim_q;
    resp_data_d     = resp_data_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = rsp_rdata_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    way_wr_en       = '0;
    wr_data         = req_wdata_q;
    wr_dirty        = 1'b0;
    rr_we           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_we_d    = req_we;
          req_addr_d  = req_addr;
          req_wdata_d = req_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (any_hit) begin
          if (req_we_q) begin
            way_wr_en[hit_way] = 1'b1;
            wr_dirty           = 1'b1;
            resp_data_d        = req_wdata_q;
          end else begin
            resp_data_d = way_data[hit_way];
          end
          state_d = S_RESPOND;
        end else begin
          victim_d = victim_sel;
          rr_we    = !any_invalid;
          mem_req_valid_d = 1'b1;
          if (way_valid[victim_sel] && way_dirty[victim_sel]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {way_tag[victim_sel], req_index};
            mem_wdata_d = way_data[victim_sel];
            state_d     = S_WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = req_addr_q;
            state_d    = S_REFILL_REQ;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_req_ready) begin
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr_q;
          state_d    = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (mem_rsp_valid) begin
          way_wr_en[victim_q] = 1'b1;
          wr_data             = req_we_q ? req_wdata_q : mem_rdata;
          wr_dirty            = req_we_q;
          resp_data_d         = wr_data;
          state_d             = S_RESPOND;
        end
      end
      S_RESPOND: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = resp_data_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      req_ready_q     <= 1'b0;
      req_we_q        <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      victim_q        <= '0;
      resp_data_q     <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      req_we_q        <= req_we_d;
      req_addr_q      <= req_addr_d;
      req_wdata_q     <= req_wdata_d;
      victim_q        <= victim_d;
      resp_data_q     <= resp_data_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  // Round-robin pointer only moves when every way of the set was valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (rr_we) begin
      rr_q[req_index] <= rr_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_LOOKUP) begin
      if (any_hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
